mem_arbiter: RTL and testbench

//  Parametrised N-port memory arbiter between the pipeline fetch/data requesters and the single cpu memory port.
//  - Sits between the stages (IF read_req/read_ack, MEM stage) and mem_read/mem_write/mem_ack/mem_addr.
//  - Round-robin grant, one outstanding transaction, registered memory-side outputs.
//  - Optional watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port among NUM_PORTS
// requesters. One transaction at a time, IDLE -> BUSY -> DONE -> IDLE, with
// every memory-side and requester-side output registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort transactions that the
// memory never acknowledges within TIMEOUT_CYCLES busy cycles.
module mem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ack,
  output logic [NUM_PORTS-1:0]        req_err,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        busy,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_read_data
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Reject configurations the arbiter cannot implement.
  if (NUM_PORTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_arbiter: NUM_PORTS and TIMEOUT_CYCLES must both be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic                   found;
  logic [PTR_W-1:0]       win;
  logic [PTR_W-1:0]       cand;
  logic [NUM_PORTS-1:0]   grant_nxt;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt;
`else
  // Without the watchdog a transaction can never be aborted.
  assign req_err = '0;
`endif

  // Round-robin search starting one past the last winner; the pointer itself
  // is checked last so a lone requester is still served back to back.
  always_comb begin
    found     = 1'b0;
    win       = ptr;
    cand      = '0;
    grant_nxt = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && (req_read[cand] || req_write[cand])) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant_nxt[win] = 1'b1;
  end

  // Arbitration FSM; all outputs are registered and pulses default low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= PTR_W'(NUM_PORTS - 1);
      req_ack        <= '0;
      req_rdata      <= '0;
      grant          <= '0;
      busy           <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      req_err        <= '0;
      cnt            <= '0;
`endif
    end else begin
      req_ack <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      req_err <= '0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state          <= BUSY;
            ptr            <= win;
            grant          <= grant_nxt;
            busy           <= 1'b1;
            // A port raising both read and write is treated as a write.
            mem_write      <= req_write[win];
            mem_read       <= ~req_write[win];
            mem_addr       <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            mem_write_data <= req_wdata[int'(win)*DATA_W +: DATA_W];
`ifdef MEM_ARB_TIMEOUT_EN
            cnt            <= '0;
`endif
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            req_rdata <= mem_write ? '0 : mem_read_data;
            req_ack   <= grant;
            state     <= DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Last allowed busy cycle passed without mem_ack: abort.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            req_rdata <= '0;
            req_ack   <= grant;
            req_err   <= grant;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions plus hand-written sequences for
// round-robin fairness, idle mem_ack, reset during BUSY and the watchdog.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_read, req_write, req_ack, req_err, grant;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] req_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        busy, mem_read, mem_write, mem_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 1;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          port;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          dly;
    bit          drop;
    bit          exp_write;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_err(req_err), .req_rdata(req_rdata), .grant(grant), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_ack(mem_ack),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (req_ack != 2'b00 || req_err != 2'b00)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", {req_ack, req_err}, 4'b0000);
      end else begin
        e = sb.pop_front();
        check("sb_ack", req_ack, e.ack);
        check("sb_err", req_err, e.err);
        check("sb_rdata", req_rdata, e.rdata);
      end
    end
  end

  task automatic drive(input int p, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd);
    req_read[p]  = rd;
    req_write[p] = wr;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = wd;
  endtask

  // Serve one granted transaction, starting from the IDLE negedge before the grant edge.
  task automatic serve(input int p, input bit exp_wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md,
                       input logic [31:0] exp_rd, input int dly,
                       input bit drop_early, input bit keep_req, input string tag);
    exp_t e;
    int lat;
    e.ack = 2'b01 << p;
    e.err = 2'b00;
    e.rdata = exp_rd;
    sb.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(mem_read || mem_write) && lat < 20);
    check({tag, "_latency"}, lat, 1);
    check({tag, "_grant"}, grant, 2'b01 << p);
    check({tag, "_strobe"}, {busy, mem_read, mem_write}, {1'b1, ~exp_wr, exp_wr});
    check({tag, "_addr"}, mem_addr, a);
    if (exp_wr) check({tag, "_wdata"}, mem_write_data, wd);
    if (drop_early) begin
      req_read[p]  = 1'b0;
      req_write[p] = 1'b0;
    end
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {mem_read, mem_write, mem_addr, req_ack},
            {~exp_wr, exp_wr, a, 2'b00});
    end
    mem_ack = 1'b1;
    mem_read_data = md;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    mem_read_data = 32'h5A5A_5A5A;
    if (!keep_req) begin
      req_read[p]  = 1'b0;
      req_write[p] = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"}, {mem_read, mem_write, busy}, 3'b001);
    @(negedge clk);
    check({tag, "_idle"}, {busy, grant}, 3'b000);
    check({tag, "_rdata_hold"}, req_rdata, exp_rd);
    model_ptr = p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_p;
    vecs[0] = '{0, 1'b1, 1'b0, 32'h100,      32'h0,        32'hCAFEF00D, 3, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF, 32'h11111111, 2, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1, 1'b1, 1'b0, 32'h2000,     32'h0,        32'h12345678, 1, 1'b0, 1'b0, 32'h12345678};
    vecs[3] = '{0, 1'b1, 1'b1, 32'h80,       32'h0A0B0C0D, 32'hFFFF0000, 1, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h300,      32'h0,        32'h55AA55AA, 4, 1'b1, 1'b0, 32'h55AA55AA};
    vecs[5] = '{1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h22222222, 1, 1'b0, 1'b1, 32'h0};

    reset = 1'b0;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {req_ack, req_err, req_rdata, grant, busy, mem_read, mem_write, mem_addr, mem_write_data},
          '0);
    reset = 1'b1;
    @(negedge clk);

    // Table of single-requester transactions.
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].port, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      serve(vecs[v].port, vecs[v].exp_write, vecs[v].addr, vecs[v].wdata, vecs[v].mdata,
            vecs[v].exp_rdata, vecs[v].dly, vecs[v].drop, 1'b0, $sformatf("vec%0d", v));
    end

    // Both ports request continuously: grants must alternate.
    drive(0, 1'b1, 1'b0, 32'hA000, 32'h0);
    drive(1, 1'b1, 1'b0, 32'hB000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_p = (model_ptr + 1) % 2;
      if (i == 3) req_read[1 - exp_p] = 1'b0;
      serve(exp_p, 1'b0, (exp_p == 0) ? 32'hA000 : 32'hB000, 32'h0,
            32'h1000 + i, 32'h1000 + i, 1, 1'b0, (i < 3), $sformatf("rr%0d", i));
    end

    // mem_ack while idle must be ignored.
    mem_ack = 1'b1;
    mem_read_data = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_ignored", {busy, req_ack, mem_read, mem_write, req_rdata},
          {1'b0, 2'b00, 1'b0, 1'b0, 32'h1003});

    // Reset in the middle of BUSY, then port 0 wins first after release.
    drive(1, 1'b1, 1'b0, 32'hC100, 32'h0);
    drive(0, 1'b1, 1'b0, 32'hC000, 32'h0);
    @(negedge clk);
    check("pre_reset_busy", {busy, mem_read}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {mem_read, mem_write, grant, busy, req_ack}, '0);
    model_ptr = 1;
    @(negedge clk);
    reset = 1'b1;
    serve(0, 1'b0, 32'hC000, 32'h0, 32'h0C0C0C0C, 32'h0C0C0C0C, 2, 1'b0, 1'b0, "post_reset0");
    serve(1, 1'b0, 32'hC100, 32'h0, 32'h1C1C1C1C, 32'h1C1C1C1C, 1, 1'b0, 1'b0, "post_reset1");

    // Memory never acknowledges.
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      exp_t e;
      drive(0, 1'b1, 1'b0, 32'hD000, 32'h0);
      e.ack = 2'b01; e.err = 2'b01; e.rdata = 32'h0;
      sb.push_back(e);
      @(negedge clk);
      check("to_strobe", {busy, mem_read}, 2'b11);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("to_hold", {mem_read, req_ack}, 3'b100);
      end
      @(posedge clk);
      #1;
      req_read[0] = 1'b0;
      @(negedge clk);
      check("to_abort", {mem_read, busy, req_ack, req_err}, {1'b0, 1'b1, 2'b01, 2'b01});
      @(negedge clk);
      check("to_idle", {busy, grant}, 3'b000);
    end
`else
    drive(0, 1'b1, 1'b0, 32'hD000, 32'h0);
    serve(0, 1'b0, 32'hD000, 32'h0, 32'h77777777, 32'h77777777, 12, 1'b0, 1'b0, "no_timeout");
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
